serial_byte_rx: RTL and testbench
=================================

SERIAL_BYTE_RX -- requirements
Module: serial_byte_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port din: input, 1 bit, serial line bit, already registered upstream by the team's D flip-flop stage.
REQ-006 Port bit_en: input, 1 bit, bit strobe; din is sampled only on edges where bit_en=1.
REQ-007 Port data_out: output, DATA_W bits, last received data word.
REQ-008 Port valid: output, 1 bit, one-cycle pulse marking data_out as newly updated.
REQ-009 Port par_err: output, 1 bit, one-cycle pulse marking a parity mismatch.
REQ-010 Port frame_err: output, 1 bit, one-cycle pulse marking a bad stop bit.
REQ-011 Port busy: output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY, STOP; no other state is reachable.
REQ-013 IDLE: with bit_en=1 and din=0 (start bit), the FSM SHALL go to DATA and clear the bit counter; din=1 keeps IDLE.
REQ-014 DATA: each bit_en=1 edge SHALL shift din into a shift register LSB-first and increment the bit counter.
REQ-015 After the DATA_W-th data bit the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-016 PARITY: on bit_en=1 the FSM SHALL latch the parity mismatch (XOR of all data bits XOR din, nonzero means mismatch) and go to STOP.
REQ-017 STOP: on bit_en=1 the FSM SHALL return to IDLE; with din=1 and no parity mismatch, data_out SHALL load the shift register and valid SHALL pulse.
REQ-018 STOP with din=1 and a parity mismatch: par_err SHALL pulse, valid SHALL stay low and data_out SHALL keep its old value.
REQ-019 STOP with din=0: frame_err SHALL pulse, valid and par_err SHALL stay low, data_out SHALL keep its old value, and the FSM SHALL return to IDLE.
REQ-020 valid, par_err and frame_err SHALL assert on the clock edge that samples the stop bit and SHALL be high for exactly one clock; at most one of them is high at a time.
REQ-021 With bit_en=0 the FSM, the counter and the shift register SHALL hold; pulse outputs SHALL be low.
REQ-022 With bit_en held at 1 continuously, frames SHALL be received back-to-back; a start bit sampled on the edge after STOP SHALL be accepted.
REQ-023 The bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-024 While rst=1 (asynchronous), state SHALL be IDLE; data_out, the shift register, the counter, the parity latch, valid, par_err, frame_err and busy SHALL be 0.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no pulse output; reception resumes at the first start bit after rst deasserts.

Structure
REQ-026 Package serial_rx_pkg SHALL hold the FSM state enum and the localparams for the start bit (0) and the stop bit (1).
REQ-027 Sub-module rx_bit_counter SHALL hold the clear/increment counter and its terminal-count flag (count == DATA_W-1 with bit_en=1).
REQ-028 The RTL SHALL be synthesizable with no latches and a single clock domain.

Verification
REQ-029 Frame 0, bits 1,0,1,0,0,1,0,1 (LSB first, word 0xA5), parity 0, stop 1, with bit_en=1 every cycle -> one valid pulse, data_out=0xA5, busy low afterwards.
REQ-030 Same frame but parity bit 1 -> one par_err pulse, no valid pulse, data_out keeps its prior value.
REQ-031 Frame for 0x3C with stop bit 0 -> one frame_err pulse, no valid pulse, FSM back in IDLE.
REQ-032 rst pulsed after 4 data bits, then a clean frame for 0x5A -> no pulse for the aborted frame, then valid with data_out=0x5A.
REQ-033 bit_en asserted once every 4 clocks during frame 0xFF -> valid only after the 11th strobe; all pulse outputs are exactly 1 clock wide.
REQ-034 PARITY_EN=0, back-to-back frames 0x01 then 0x80 -> two valid pulses 10 strobes apart, data_out=0x01 then 0x80.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial byte receiver: FSM state encoding and
// the line levels of the start and stop bits.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the serial receiver: clear on start bit, count data bits,
// flag the last data bit so the FSM can leave DATA on the same strobe.
module rx_bit_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && bit_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count tops out at DATA_W after the last bit, so it never wraps.
  assign tc = bit_en && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_byte_rx.sv
// Strobed serial frame receiver: start bit, DATA_W bits LSB first, optional
// even parity, stop bit; reports each frame with a one-clock status pulse.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy
);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W:0]   sh_in;
  logic              par_mis_q, par_mis_d;
  logic              valid_q, valid_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;
  logic              cnt_clr, cnt_inc, cnt_tc;

  rx_bit_counter #(
    .DATA_W (DATA_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .bit_en (bit_en),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .tc     (cnt_tc)
  );

  // New bit enters at the MSB so the first received bit ends up at bit 0.
  assign sh_in = {din, sh_q};

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    dout_d      = dout_q;
    par_mis_d   = par_mis_q;
    valid_d     = 1'b0;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (din == START_BIT) begin
            state_d   = DATA;
            cnt_clr   = 1'b1;
            par_mis_d = 1'b0;
          end
        end
        DATA: begin
          sh_d    = sh_in[DATA_W:1];
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_mis_d = (^sh_q) ^ din;
          state_d   = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din != STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (par_mis_q) begin
            par_err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            dout_d  = sh_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      dout_q      <= '0;
      par_mis_q   <= 1'b0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      dout_q      <= dout_d;
      par_mis_q   <= par_mis_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = dout_q;
  assign valid     = valid_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Scoreboard bench: side 0 receives with even parity, side 1 without; the
// stimulus pushes expected frame outcomes, a monitor pops them on each pulse.
module tb_serial_byte_rx;

  localparam int KIND_VALID = 0;
  localparam int KIND_PAR   = 1;
  localparam int KIND_FRAME = 2;

  typedef struct {
    int         kind;
    logic [7:0] dout;
    int         at;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       din       [2];
  logic       bit_en    [2];
  logic [7:0] data_out  [2];
  logic       valid     [2];
  logic       par_err   [2];
  logic       frame_err [2];
  logic       busy      [2];

  exp_t       exp_q [2][$];
  logic [7:0] model_dout [2];
  int         issued [2];
  int         seen   [2];
  logic [2:0] prev_pulses [2];
  int         n_checks;
  int         n_fail;

  serial_byte_rx #(.DATA_W(8), .PARITY_EN(1)) dut_par (
    .clk       (clk),
    .rst       (rst),
    .din       (din[0]),
    .bit_en    (bit_en[0]),
    .data_out  (data_out[0]),
    .valid     (valid[0]),
    .par_err   (par_err[0]),
    .frame_err (frame_err[0]),
    .busy      (busy[0])
  );

  serial_byte_rx #(.DATA_W(8), .PARITY_EN(0)) dut_nopar (
    .clk       (clk),
    .rst       (rst),
    .din       (din[1]),
    .bit_en    (bit_en[1]),
    .data_out  (data_out[1]),
    .valid     (valid[1]),
    .par_err   (par_err[1]),
    .frame_err (frame_err[1]),
    .busy      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes actually presented to each DUT, counted at the sampling edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bit_en[i] && !rst) seen[i]++;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] p;
      exp_t e;
      p = {frame_err[i], par_err[i], valid[i]};
      if (p != 3'b000) begin
        check($sformatf("s%0d_onehot", i), 32'($countones(p)), 32'd1);
        check($sformatf("s%0d_pulse_width", i), 32'(prev_pulses[i] & p), 32'd0);
        if (exp_q[i].size() == 0) begin
          check($sformatf("s%0d_unexpected_pulse", i), 32'(p), 32'd0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("s%0d_kind", i), 32'(p), 32'(3'b001 << e.kind));
          check($sformatf("s%0d_strobe_index", i), 32'(seen[i]), 32'(e.at));
          check($sformatf("s%0d_data_out", i), 32'(data_out[i]), 32'(e.dout));
        end
      end
      prev_pulses[i] = p;
    end
  end

  task automatic send_bit(input int side, input logic b, input int gap);
    @(negedge clk);
    din[side]    = b;
    bit_en[side] = 1'b1;
    issued[side]++;
    repeat (gap) begin
      @(negedge clk);
      bit_en[side] = 1'b0;
      din[side]    = 1'($urandom);
    end
  endtask

  task automatic send_idle(input int side, input int n);
    repeat (n) send_bit(side, 1'b1, 0);
  endtask

  // Reference outcome: stop bit first, then even parity over data and parity bit.
  task automatic send_frame(input int side, input logic [7:0] data, input logic flip_par,
                            input logic stop_bit, input int gap);
    exp_t e;
    int   nbits;
    logic par_bit;
    nbits   = (side == 0) ? 11 : 10;
    par_bit = (^data) ^ flip_par;
    if (stop_bit == 1'b0) begin
      e.kind = KIND_FRAME;
    end else if (side == 0 && flip_par) begin
      e.kind = KIND_PAR;
    end else begin
      e.kind = KIND_VALID;
      model_dout[side] = data;
    end
    e.dout = model_dout[side];
    e.at   = issued[side] + nbits;
    exp_q[side].push_back(e);
    send_bit(side, 1'b0, gap);
    for (int j = 0; j < 8; j++) send_bit(side, data[j], gap);
    if (side == 0) send_bit(side, par_bit, gap);
    send_bit(side, stop_bit, gap);
  endtask

  task automatic finish_frame(input int side, input string name);
    @(negedge clk);
    bit_en[side] = 1'b0;
    din[side]    = 1'b1;
    check(name, 32'(busy[side]), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_s%0d_busy", tag, i), 32'(busy[i]), 32'd0);
      check($sformatf("%s_s%0d_data_out", tag, i), 32'(data_out[i]), 32'd0);
      check($sformatf("%s_s%0d_pulses", tag, i),
            32'({frame_err[i], par_err[i], valid[i]}), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 2; i++) begin
      din[i]         = 1'b1;
      bit_en[i]      = 1'b0;
      model_dout[i]  = '0;
      issued[i]      = 0;
      seen[i]        = 0;
      prev_pulses[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Clean 0xA5, then corrupted parity, then a bad stop bit.
    send_idle(0, 2);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    finish_frame(0, "a5_busy_after");
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
    finish_frame(0, "parerr_busy_after");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
    finish_frame(0, "frameerr_idle_after");

    // Abort a 0x5A frame after four data bits with a reset pulse.
    send_bit(0, 1'b0, 0);
    for (int j = 0; j < 4; j++) send_bit(0, 1'($urandom), 0);
    @(negedge clk);
    bit_en[0] = 1'b0;
    check("abort_busy_midframe", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    model_dout[0] = '0;
    model_dout[1] = '0;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
    finish_frame(0, "5a_busy_after");

    // Sparse strobes: one every 4 clocks.
    send_frame(0, 8'hFF, 1'b0, 1'b1, 3);
    finish_frame(0, "ff_sparse_busy_after");

    // Random back-to-back frames with the parity receiver.
    for (int k = 0; k < 20; k++) begin
      int r;
      r = int'($urandom_range(0, 3));
      send_frame(0, 8'($urandom), (r == 2), (r != 3), int'($urandom_range(0, 2)));
    end
    finish_frame(0, "random_s0_busy_after");

    // No-parity receiver: back-to-back 0x01 then 0x80, then random frames.
    send_idle(1, 1);
    send_frame(1, 8'h01, 1'b0, 1'b1, 0);
    send_frame(1, 8'h80, 1'b0, 1'b1, 0);
    finish_frame(1, "nopar_busy_after");
    for (int k = 0; k < 10; k++) begin
      send_frame(1, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1)));
    end
    finish_frame(1, "random_s1_busy_after");

    for (int i = 0; i < 2; i++) begin
      int budget;
      budget = 20;
      while (exp_q[i].size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check($sformatf("s%0d_missing_pulses", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
